// File: rtl/uart_hex_pkg.sv
// Shared types and helpers for the hex-dump UART transmitter.
package uart_hex_pkg;

  // Serializer phases for one 8N1 character.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Pending end-of-line characters still owed after a full line of digits.
  typedef enum logic [1:0] {
    NONE,
    CR,
    LF
  } eol_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Upper-case ASCII hex digit for a 4-bit value.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    return (n < 4'd10) ? (8'h30 + n8) : (8'h37 + n8);
  endfunction

endpackage

// File: rtl/uart_hex_tx_uart_tx_8n1.sv
// 8N1 UART serializer: baud counter plus LSB-first shift register.
// A byte is accepted on i_load only while o_busy is low; o_txd and o_busy
// are registered, so the start bit appears the cycle after the load.
module uart_tx_8n1
  import uart_hex_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_txd,
  output logic       o_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic             txd_q;
  logic             busy_q;
  logic             bit_end;

  // Last clock of the current bit period.
  always_comb begin
    bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  end

  // Character FSM: start bit, 8 data bits LSB first, stop bit, then idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (i_load) begin
            shreg_q <= i_byte;
            cnt_q   <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = busy_q;

endmodule

// File: rtl/uart_hex_tx.sv
// Drains a FWFT nibble FIFO and prints each nibble as an ASCII hex digit on
// an 8N1 UART, optionally terminating every NIBS_PER_LINE digits with CR LF.
module uart_hex_tx
  import uart_hex_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int NIBS_PER_LINE = 8,
  parameter bit EOL_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_rdat,
  input  logic       i_empty,
  output logic       o_rreq,
  output logic       o_txd,
  output logic       o_busy
);

  localparam int LINE_W = $clog2(NIBS_PER_LINE + 1);

  eol_e              eol_q;
  logic [LINE_W-1:0] line_q;
  logic              tx_busy;
  logic              tx_load;
  logic [7:0]        tx_byte;
  logic              nib_pop;

  // Character selection: owed CR/LF take priority over new FIFO data, so the
  // FIFO is only popped when no end-of-line is pending and the serializer is idle.
  always_comb begin
    nib_pop = !tx_busy && !i_empty && (eol_q == NONE) && !rst;
    tx_load = 1'b0;
    tx_byte = '0;
    if (!tx_busy) begin
      if (eol_q == CR) begin
        tx_load = 1'b1;
        tx_byte = ASCII_CR;
      end else if (eol_q == LF) begin
        tx_load = 1'b1;
        tx_byte = ASCII_LF;
      end else if (!i_empty) begin
        tx_load = 1'b1;
        tx_byte = nib2ascii(i_rdat);
      end
    end
  end

  // Line counting and the CR -> LF -> NONE end-of-line sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eol_q  <= NONE;
      line_q <= '0;
    end else if (!tx_busy) begin
      case (eol_q)
        CR:      eol_q <= LF;
        LF:      eol_q <= NONE;
        default: begin
          if (nib_pop && EOL_EN) begin
            if (line_q == LINE_W'(NIBS_PER_LINE - 1)) begin
              line_q <= '0;
              eol_q  <= CR;
            end else begin
              line_q <= line_q + LINE_W'(1);
            end
          end
        end
      endcase
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .i_load(tx_load),
    .i_byte(tx_byte),
    .o_txd (o_txd),
    .o_busy(tx_busy)
  );

  assign o_rreq = nib_pop;
  assign o_busy = tx_busy;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Scoreboard bench: three instances (fast with CR LF, fast without, full-rate
// baud), a FIFO model per instance, and a UART receiver that checks framing,
// bit widths and the decoded character stream against expected queues.
module tb_uart_hex_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] empty_v;
  logic [2:0] rreq_v;
  logic [2:0] txd_v;
  logic [2:0] busy_v;
  logic [3:0] rdat_v [3];

  uart_hex_tx #(.CLKS_PER_BIT(4), .NIBS_PER_LINE(8), .EOL_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .i_rdat(rdat_v[0]), .i_empty(empty_v[0]),
    .o_rreq(rreq_v[0]), .o_txd(txd_v[0]), .o_busy(busy_v[0]));
  uart_hex_tx #(.CLKS_PER_BIT(4), .NIBS_PER_LINE(8), .EOL_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst_v[1]), .i_rdat(rdat_v[1]), .i_empty(empty_v[1]),
    .o_rreq(rreq_v[1]), .o_txd(txd_v[1]), .o_busy(busy_v[1]));
  uart_hex_tx #(.CLKS_PER_BIT(868), .NIBS_PER_LINE(8), .EOL_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst_v[2]), .i_rdat(rdat_v[2]), .i_empty(empty_v[2]),
    .o_rreq(rreq_v[2]), .o_txd(txd_v[2]), .o_busy(busy_v[2]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int cpb [3] = '{4, 4, 868};
  bit eol [3] = '{1'b1, 1'b0, 1'b1};

  logic [3:0] fifo_q [3][$];
  logic [7:0] exp_q  [3][$];
  int         nib_cnt [3];
  int         pops    [3];
  bit         pend    [3];

  bit         act    [3];
  int         idx    [3];
  logic [7:0] rxb    [3];
  logic       prevtx [3];
  bit         wok    [3];
  int         startq [3][$];

  string hexs = "0123456789ABCDEF";

  task automatic chk(input bit ok, input string name, input int act_v, input int req_v);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act_v, req_v, $time);
    end
  endtask

  // Drive FIFO head/empty from the model; data is random while empty.
  task automatic upd(input int d);
    empty_v[d] = (fifo_q[d].size() == 0);
    rdat_v[d]  = (fifo_q[d].size() != 0) ? fifo_q[d][0] : 4'($urandom_range(15));
  endtask

  // Reference: one hex digit per nibble, CR LF after every 8th since reset.
  task automatic push_nib(input int d, input logic [3:0] n);
    fifo_q[d].push_back(n);
    exp_q[d].push_back(hexs[n]);
    if (eol[d]) begin
      nib_cnt[d]++;
      if (nib_cnt[d] == 8) begin
        exp_q[d].push_back(8'h0D);
        exp_q[d].push_back(8'h0A);
        nib_cnt[d] = 0;
      end
    end
    upd(d);
  endtask

  task automatic push_word(input int d, input logic [31:0] w);
    for (int i = 7; i >= 0; i--) push_nib(d, w[i*4 +: 4]);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int d, input int budget);
    int n;
    n = 0;
    while ((exp_q[d].size() != 0 || fifo_q[d].size() != 0 || act[d]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(n < budget, "drain timeout", n, budget);
    sync();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: a pop happens on the edge following a cycle with o_rreq high.
  initial begin
    for (int d = 0; d < 3; d++) begin
      pops[d] = 0;
      pend[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) pend[d] = rreq_v[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (pend[d]) begin
          pops[d]++;
          if (fifo_q[d].size() != 0) void'(fifo_q[d].pop_front());
          upd(d);
        end
      end
    end
  end

  // UART receiver / monitor: sampled on the falling edge, mid-bit decode.
  initial begin
    for (int d = 0; d < 3; d++) begin
      act[d]    = 1'b0;
      idx[d]    = 0;
      prevtx[d] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst_v[d]) begin
          act[d] = 1'b0;
        end else if (!act[d]) begin
          if (txd_v[d] == 1'b0) begin
            act[d] = 1'b1;
            idx[d] = 0;
            rxb[d] = '0;
            wok[d] = 1'b1;
            startq[d].push_back(cyc);
          end
        end else begin
          int k;
          int r;
          idx[d]++;
          k = idx[d] / cpb[d];
          r = idx[d] % cpb[d];
          if (k < 10 && r != 0 && txd_v[d] != prevtx[d]) wok[d] = 1'b0;
          if (r == cpb[d] / 2) begin
            if (k == 0) begin
              chk(txd_v[d] == 1'b0, "start bit", int'(txd_v[d]), 0);
            end else if (k <= 8) begin
              rxb[d][k-1] = txd_v[d];
            end else if (k == 9) begin
              chk(txd_v[d] == 1'b1, "stop bit", int'(txd_v[d]), 1);
              chk(busy_v[d] == 1'b1, "busy in stop", int'(busy_v[d]), 1);
              if (exp_q[d].size() == 0) begin
                chk(1'b0, "unexpected char", int'(rxb[d]), 0);
              end else begin
                logic [7:0] e;
                e = exp_q[d].pop_front();
                chk(rxb[d] == e, "char", int'(rxb[d]), int'(e));
              end
            end
          end
          if (idx[d] == 10 * cpb[d]) begin
            chk(wok[d], "bit width", 0, 1);
            chk(busy_v[d] == 1'b0, "busy after stop", int'(busy_v[d]), 0);
            act[d] = 1'b0;
          end
        end
        prevtx[d] = txd_v[d];
      end
    end
  end

  initial begin
    bit   ok;
    int   n;
    int   p0;
    rst_v = '1;
    for (int d = 0; d < 3; d++) begin
      nib_cnt[d] = 0;
      upd(d);
    end

    // Reset with data present: idle outputs, no pop.
    push_word(0, 32'h1234ABCD);
    push_word(1, 32'hDEADBEEF);
    push_word(1, 32'h00000009);
    push_nib(2, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(txd_v[0] == 1'b1, "reset txd", int'(txd_v[0]), 1);
    chk(rreq_v[0] == 1'b0, "reset rreq", int'(rreq_v[0]), 0);
    chk(busy_v[0] == 1'b0, "reset busy", int'(busy_v[0]), 0);
    chk(txd_v[2] == 1'b1, "reset txd slow", int'(txd_v[2]), 1);
    sync();
    rst_v = '0;
    @(negedge clk);
    chk(rreq_v[0] == 1'b1, "first rreq", int'(rreq_v[0]), 1);
    sync();

    // One full line: 8 digits then CR LF, 41-cycle char period.
    wait_drain(0, 2000);
    chk(pops[0] == 8, "pops word", pops[0], 8);
    chk(startq[0].size() == 10, "char count", startq[0].size(), 10);
    for (int i = 1; i < startq[0].size(); i++)
      chk(startq[0][i] - startq[0][i-1] == 41, "char period", startq[0][i] - startq[0][i-1], 41);
    startq[0].delete();

    wait_drain(1, 2000);
    chk(pops[1] == 16, "pops no-eol", pops[1], 16);

    // Stall mid-line: 3 nibbles, long gap, 5 more; CR LF only after the 8th.
    for (int i = 0; i < 3; i++) push_nib(0, 4'($urandom_range(15)));
    wait_drain(0, 1000);
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd_v[0] != 1'b1 || busy_v[0] != 1'b0) ok = 1'b0;
    end
    chk(ok, "idle during gap", 0, 1);
    sync();
    for (int i = 0; i < 5; i++) push_nib(0, 4'($urandom_range(15)));
    wait_drain(0, 1000);
    chk(pops[0] == 16, "pops after stall", pops[0], 16);

    // Reset during data bit 3 of '1' (bit 3 is 0).
    push_word(0, 32'h1234ABCD);
    n = 0;
    while (!(act[0] && idx[0] == 4 * 4 + 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(n < 500, "reach bit3 timeout", n, 500);
    sync();
    chk(txd_v[0] == 1'b0, "txd before reset", int'(txd_v[0]), 0);
    rst_v[0] = 1'b1;
    #1;
    chk(txd_v[0] == 1'b1, "async reset txd", int'(txd_v[0]), 1);
    chk(busy_v[0] == 1'b0, "async reset busy", int'(busy_v[0]), 0);
    chk(rreq_v[0] == 1'b0, "async reset rreq", int'(rreq_v[0]), 0);
    fifo_q[0].delete();
    exp_q[0].delete();
    nib_cnt[0] = 0;
    upd(0);
    repeat (3) @(posedge clk);
    #2;
    rst_v[0] = 1'b0;
    p0 = pops[0];
    push_word(0, 32'hCAFE0123);
    wait_drain(0, 2000);
    chk(pops[0] - p0 == 8, "pops after reset", pops[0] - p0, 8);

    // Random words with random gaps on both fast instances.
    for (int i = 0; i < 4; i++) begin
      push_word(0, $urandom);
      push_word(1, $urandom);
      repeat ($urandom_range(60)) @(posedge clk);
      #2;
    end
    wait_drain(0, 5000);
    wait_drain(1, 5000);
    chk(pops[1] == 48, "pops random", pops[1], 48);

    // Full-rate instance: single 'F'.
    wait_drain(2, 12000);
    chk(pops[2] == 1, "pops slow", pops[2], 1);
    for (int d = 0; d < 3; d++)
      chk(exp_q[d].size() == 0, "leftover expected", exp_q[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
